aes_serial_loader: RTL and testbench
====================================

# aes_serial_loader

Parametrised serial-to-parallel front end for the AES-128 CBC datapath. Deserialises CHANNELS independent bit streams (plaintext, key, IV by default) of WIDTH bits each into parallel words. It then presents them to the cipher core with a valid/ready handshake. Compared with the fixed 128-bit, three-stream serial input, it adds configurable width, channel count and bit order, plus back-pressure, abort and overrun detection.

## Interface
Parameters:
- WIDTH, 128, bits per channel per frame (≥ 2)
- CHANNELS, 3, number of parallel serial streams (ch0 = data, ch1 = key, ch2 = IV by convention)
- MSB_FIRST, 1, 1: first received bit lands in bit WIDTH-1; 0: first bit lands in bit 0

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_bits  in  CHANNELS  one serial bit per channel, sampled when s_valid && s_ready
- s_valid  in  1  s_bits valid this cycle
- s_ready  out  1  loader accepts a bit this cycle
- s_abort  in  1  synchronous frame abort
- p_data  out  CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH]
- p_valid  out  1  complete frame available
- p_ready  in  1  core consumes frame
- busy  out  1  frame partially received (the serial-input-in-progress flag)
- bit_cnt  out  $clog2(WIDTH+1)  bits accepted in current frame
- overrun  out  1  sticky: s_valid seen while s_ready low
- clr_err  in  1  synchronous clear of overrun

## Operation
- FSM states: IDLE, SHIFT, FULL.
- IDLE: s_ready=1. On an accepted bit, shift it into every channel register, set bit_cnt=1 and go to SHIFT. With WIDTH=… no special case: WIDTH ≥ 2.
- SHIFT: s_ready=1 and busy=1. Each accepted bit shifts in and increments bit_cnt. On the accept that makes bit_cnt == WIDTH, go to FULL.
- MSB_FIRST=1: reg <= {reg[WIDTH-2:0], bit}. MSB_FIRST=0: reg <= {bit, reg[WIDTH-1:1]}. Both orders give the first bit at the stated end after WIDTH shifts.
- FULL: p_valid=1, s_ready=0, busy=0, and p_data is held stable. On p_valid && p_ready, go to IDLE, clear bit_cnt and keep p_data (not cleared). There is no same-cycle bypass: a bit offered in the handshake cycle is not accepted.
- s_valid low in SHIFT: hold state and count, with no timeout.
- s_abort (any state): next state IDLE, bit_cnt=0, p_valid deasserts. It has priority over s_valid and p_ready in the same cycle. Channel registers keep their contents.
- overrun: set on any cycle with s_valid=1 and s_ready=0. Cleared by clr_err. Set wins if both occur in the same cycle.
- rst_n low (including mid-frame): state IDLE and all registers cleared immediately.

## Timing
- Reset values: s_ready=1, p_valid=0, busy=0, bit_cnt=0, overrun=0, p_data=0.
- With continuous s_valid, bit k (k = 1..WIDTH) is accepted at edge k. p_valid rises after edge WIDTH, i.e. in cycle WIDTH+1 counted from the first accept.
- Minimum frame period is WIDTH+1 cycles (one FULL cycle with p_ready held high).
- p_ready high before p_valid has no effect.
- All outputs are registered except s_ready and p_valid, which decode directly from state.

## Test plan
- Reset, then 128 bits MSB-first with ch0=596F75617265746865626573746D616E, ch1=416264756C4D6F697A536865696B686B, ch2=74686973697363686169746869736973, p_ready=1 -> p_valid is high in cycle 129 and p_data matches all three words exactly; busy is high for cycles 2–128.
- MSB_FIRST=0, WIDTH=8, CHANNELS=1, bits 1,0,0,0,0,0,0,0 -> p_data=8'h01. With MSB_FIRST=1 the same stream gives 8'h80.
- Full frame with p_ready=0 for 10 cycles while s_valid stays high -> s_ready=0, p_data stable, overrun=1 after the first offered bit. clr_err then clears overrun. Raising p_ready returns to IDLE in one cycle.
- s_valid gaps (every other cycle, 128 bits) -> same p_data as a continuous stream, and bit_cnt increments only on accepts.
- Assert s_abort at bit_cnt=57, then send a fresh 128-bit frame -> the output equals the fresh frame only. s_abort together with s_valid leaves bit_cnt=0.
- rst_n low at bit_cnt=90 -> all outputs return to their reset values asynchronously, and the next frame loads correctly.

Source files
------------

// File: rtl/aes_serial_loader.sv
// Serial-to-parallel front end for the AES-128 CBC datapath: deserialises CHANNELS
// bit streams into WIDTH-bit words and hands complete frames over with valid/ready.
module aes_serial_loader #(
   parameter int unsigned WIDTH     = 128,
   parameter int unsigned CHANNELS  = 3,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [CHANNELS-1:0]          s_bits,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic                         s_abort,
   output logic [CHANNELS*WIDTH-1:0]    p_data,
   output logic                         p_valid,
   input  logic                         p_ready,
   output logic                         busy,
   output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
   output logic                         overrun,
   input  logic                         clr_err
);
   localparam int unsigned CNT_W  = $clog2(WIDTH+1);
   localparam int unsigned DATA_W = CHANNELS*WIDTH;

   typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                overrun_q, overrun_d;
   logic                accept;

   assign s_ready = (state_q != FULL);
   assign p_valid = (state_q == FULL);
   assign accept  = s_valid && s_ready && !s_abort;

   // Shift one bit per channel into its register on every accepted beat
   always_comb begin
      data_d = data_q;
      if (accept) begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (MSB_FIRST)
               data_d[c*WIDTH +: WIDTH] = {data_q[c*WIDTH +: WIDTH-1], s_bits[c]};
            else
               data_d[c*WIDTH +: WIDTH] = {s_bits[c], data_q[c*WIDTH+1 +: WIDTH-1]};
         end
      end
   end

   // Next state, bit count, busy flag and sticky overrun; abort overrides everything
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      overrun_d = overrun_q;
      case (state_q)
         IDLE, SHIFT: begin
            if (accept) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = (cnt_q == CNT_W'(WIDTH-1)) ? FULL : SHIFT;
            end
         end
         FULL: begin
            if (p_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      if (s_abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
      busy_d = (state_d == SHIFT);
      if (clr_err)
         overrun_d = 1'b0;
      if (s_valid && !s_ready)
         overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         data_q    <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign p_data  = data_q;
   assign bit_cnt = cnt_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_aes_serial_loader.sv
// Self-checking bench for aes_serial_loader: directed frames, an 8-bit bit-order
// table on two small instances, and a randomized run against a frame-level model.
module tb_aes_serial_loader;
   localparam int unsigned W   = 128;
   localparam int unsigned NCH = 3;
   localparam int unsigned DW  = W*NCH;
   localparam logic [127:0] W0 = 128'h596F75617265746865626573746D616E;
   localparam logic [127:0] W1 = 128'h416264756C4D6F697A536865696B686B;
   localparam logic [127:0] W2 = 128'h74686973697363686169746869736973;

   logic           clk, rst_n;
   logic [NCH-1:0] s_bits;
   logic           s_valid, s_ready, s_abort, p_valid, p_ready, busy, overrun, clr_err;
   logic [DW-1:0]  p_data;
   logic [7:0]     bit_cnt;

   logic [0:0]     sm_bits;
   logic           sm_valid, sm_abort, sm_pready, sm_clr;
   logic           l_ready, l_pvalid, l_busy, l_ovr, m_ready, m_pvalid, m_busy, m_ovr;
   logic [7:0]     l_data, m_data;
   logic [3:0]     l_cnt, m_cnt;

   int errors = 0;
   int checks = 0;

   aes_serial_loader #(.WIDTH(W), .CHANNELS(NCH), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .s_bits(s_bits), .s_valid(s_valid), .s_ready(s_ready),
      .s_abort(s_abort), .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
      .busy(busy), .bit_cnt(bit_cnt), .overrun(overrun), .clr_err(clr_err));

   aes_serial_loader #(.WIDTH(8), .CHANNELS(1), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .s_bits(sm_bits), .s_valid(sm_valid), .s_ready(l_ready),
      .s_abort(sm_abort), .p_data(l_data), .p_valid(l_pvalid), .p_ready(sm_pready),
      .busy(l_busy), .bit_cnt(l_cnt), .overrun(l_ovr), .clr_err(sm_clr));

   aes_serial_loader #(.WIDTH(8), .CHANNELS(1), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .s_bits(sm_bits), .s_valid(sm_valid), .s_ready(m_ready),
      .s_abort(sm_abort), .p_data(m_data), .p_valid(m_pvalid), .p_ready(sm_pready),
      .busy(m_busy), .bit_cnt(m_cnt), .overrun(m_ovr), .clr_err(sm_clr));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Send one full frame MSB-first; optional idle cycle before every bit
   task automatic send_frame(input logic [127:0] w0, input logic [127:0] w1,
                             input logic [127:0] w2, input bit gapped);
      int cnt = 0;
      for (int k = 0; k < int'(W); k++) begin
         if (gapped) begin
            s_valid = 1'b0;
            step();
            check("gap_hold_cnt", DW'(bit_cnt), DW'(cnt));
         end
         check("pre_busy_pvalid", DW'({p_valid, busy}), DW'({1'b0, cnt != 0}));
         s_bits  = {w2[W-1-k], w1[W-1-k], w0[W-1-k]};
         s_valid = 1'b1;
         step();
         cnt++;
         check("frame_cnt", DW'(bit_cnt), DW'(cnt));
      end
      s_valid = 1'b0;
   endtask

   task automatic send_bits(input int nbits);
      for (int k = 0; k < nbits; k++) begin
         s_bits  = NCH'($urandom);
         s_valid = 1'b1;
         step();
      end
      s_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_main"}, DW'({s_ready, p_valid, busy, bit_cnt, overrun}),
            DW'({1'b1, 1'b0, 1'b0, 8'd0, 1'b0}));
      check({tag, "_pdata"}, p_data, '0);
   endtask

   typedef struct {
      logic [7:0] seq;      // bit i is the i-th bit sent
      logic [7:0] exp_lsb;
      logic [7:0] exp_msb;
   } vec_t;

   vec_t          vecs[6];
   logic [7:0]    sq;
   logic [127:0]  r0, r1, r2;
   logic [127:0]  mw[3];
   int            n;
   bit            movr;
   logic [11:0]   exp_v;

   initial begin
      rst_n = 1'b0; s_bits = '0; s_valid = 1'b0; s_abort = 1'b0; p_ready = 1'b0; clr_err = 1'b0;
      sm_bits = '0; sm_valid = 1'b0; sm_abort = 1'b0; sm_pready = 1'b1; sm_clr = 1'b0;
      vecs = '{'{8'h01, 8'h01, 8'h80}, '{8'h03, 8'h03, 8'hC0}, '{8'h1E, 8'h1E, 8'h78},
               '{8'hF0, 8'hF0, 8'h0F}, '{8'h80, 8'h80, 8'h01}, '{8'h00, 8'h00, 8'h00}};
      step(); step();
      check_reset_values("reset");
      check("reset_small", DW'({l_ready, l_pvalid, l_busy, l_cnt, l_ovr, l_data}),
            DW'({1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00}));
      rst_n = 1'b1;
      step();

      // Known-answer frame, continuous stream
      p_ready = 1'b1;
      send_frame(W0, W1, W2, 1'b0);
      check("kat_pvalid_c129", DW'({p_valid, s_ready, busy}), DW'({1'b1, 1'b0, 1'b0}));
      check("kat_pdata", p_data, {W2, W1, W0});
      step();
      check("kat_release", DW'({p_valid, s_ready, bit_cnt}), DW'({1'b0, 1'b1, 8'd0}));
      check("kat_pdata_kept", p_data, {W2, W1, W0});

      // Bit-order table on the 8-bit single-channel instances
      for (int v = 0; v < 6; v++) begin
         sq = vecs[v].seq;
         for (int i = 0; i < 8; i++) begin
            sm_bits  = sq[i];
            sm_valid = 1'b1;
            step();
         end
         sm_valid = 1'b0;
         check("tbl_pvalid", DW'({l_pvalid, m_pvalid, l_cnt, m_cnt}), DW'({1'b1, 1'b1, 4'd8, 4'd8}));
         check("tbl_lsb_first", DW'(l_data), DW'(vecs[v].exp_lsb));
         check("tbl_msb_first", DW'(m_data), DW'(vecs[v].exp_msb));
         step();
         check("tbl_release", DW'({l_pvalid, m_pvalid, l_ready}), DW'({1'b0, 1'b0, 1'b1}));
      end

      // Back-pressure: bits offered while FULL are refused and flag overrun
      p_ready = 1'b0;
      r0 = rnd128(); r1 = rnd128(); r2 = rnd128();
      send_frame(r0, r1, r2, 1'b0);
      check("bp_overrun_before", DW'(overrun), DW'(0));
      s_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_bits = NCH'($urandom);
         step();
         check("bp_hold", DW'({s_ready, p_valid, overrun, bit_cnt}), DW'({1'b0, 1'b1, 1'b1, 8'd128}));
         check("bp_pdata_stable", p_data, {r2, r1, r0});
      end
      clr_err = 1'b1;
      step();
      check("ovr_set_wins", DW'(overrun), DW'(1));
      s_valid = 1'b0;
      step();
      check("ovr_cleared", DW'(overrun), DW'(0));
      clr_err = 1'b0;
      p_ready = 1'b1;
      step();
      check("bp_release", DW'({p_valid, s_ready, bit_cnt}), DW'({1'b0, 1'b1, 8'd0}));

      // Gapped stream must load the same words
      send_frame(W0, W1, W2, 1'b1);
      check("gap_pdata", p_data, {W2, W1, W0});
      step();

      // Abort mid-frame, then a fresh frame
      send_bits(57);
      check("abort_cnt57", DW'(bit_cnt), DW'(57));
      s_abort = 1'b1; s_valid = 1'b1;
      step();
      s_abort = 1'b0; s_valid = 1'b0;
      check("abort_state", DW'({bit_cnt, busy, s_ready, p_valid}), DW'({8'd0, 1'b0, 1'b1, 1'b0}));
      p_ready = 1'b0;
      r0 = rnd128(); r1 = rnd128(); r2 = rnd128();
      send_frame(r0, r1, r2, 1'b0);
      check("abort_fresh_pdata", p_data, {r2, r1, r0});
      s_abort = 1'b1; p_ready = 1'b1;
      step();
      s_abort = 1'b0;
      check("abort_full", DW'({p_valid, bit_cnt, s_ready}), DW'({1'b0, 8'd0, 1'b1}));
      check("abort_keeps_pdata", p_data, {r2, r1, r0});

      // Asynchronous reset mid-frame
      send_bits(90);
      check("rst_cnt90", DW'(bit_cnt), DW'(90));
      #2 rst_n = 1'b0;
      #2;
      check_reset_values("async_rst");
      step();
      rst_n = 1'b1;
      step();
      r0 = rnd128(); r1 = rnd128(); r2 = rnd128();
      send_frame(r0, r1, r2, 1'b0);
      check("post_rst_pdata", p_data, {r2, r1, r0});
      step();

      // Randomized run against a frame-level model
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n = 0; movr = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         s_valid = ($urandom_range(3) != 0);
         s_bits  = NCH'($urandom);
         p_ready = ($urandom_range(2) == 0);
         s_abort = ($urandom_range(199) == 0);
         clr_err = ($urandom_range(15) == 0);
         step();
         if (clr_err) movr = 1'b0;
         if (s_valid && n == int'(W)) movr = 1'b1;
         if (s_abort) n = 0;
         else if (n < int'(W)) begin
            if (s_valid) begin
               for (int c = 0; c < int'(NCH); c++) mw[c][W-1-n] = s_bits[c];
               n++;
            end
         end else if (p_ready) n = 0;
         exp_v = {n < int'(W), n == int'(W), n > 0 && n < int'(W), 8'(n), movr};
         check("rnd_ctrl", DW'({s_ready, p_valid, busy, bit_cnt, overrun}), DW'(exp_v));
         if (n == int'(W)) check("rnd_pdata", p_data, {mw[2], mw[1], mw[0]});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
